multicycle_cpu_core: RTL and testbench

Parametrised multicycle CPU core and the successor to the current single-top datapath. It adds configurable data, address and register-file widths. It has a five-state controller with an explicit FETCH/DECODE/EXEC/MEM/WB sequence. Instruction and data memories sit outside the core and are reached over req/ack handshake buses, so wait-state memories are supported. It also adds HALT, a run-enable input and retire/debug outputs.

---
 rtl/multicycle_cpu_core.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_cpu_core.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu_core.sv
// Multicycle CPU core: FETCH/DECODE/EXEC/MEM/WB sequencer over req/ack instruction and data buses.
// 3-5 cycles per instruction with zero-wait memories; each req cycle without ack stalls one cycle.
module multicycle_cpu_core #(
   parameter int DATA_W   = 18,
   parameter int ADDR_W   = 12,
   parameter int REG_AW   = 4,
   parameter int RESET_PC = 0,
   parameter bit R0_ZERO  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [ADDR_W-1:0] pc_out,
   output logic [2:0]        state_out,
   output logic              retire,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_AND  = 5'd2;
   localparam logic [4:0] OP_OR   = 5'd3;
   localparam logic [4:0] OP_XOR  = 5'd4;
   localparam logic [4:0] OP_ANDI = 5'd6;
   localparam logic [4:0] OP_LD   = 5'd7;
   localparam logic [4:0] OP_ST   = 5'd8;
   localparam logic [4:0] OP_BEQ  = 5'd9;
   localparam logic [4:0] OP_JMP  = 5'd10;
   localparam logic [4:0] OP_HALT = 5'd31;
   localparam int         NREG    = 1 << REG_AW;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [ADDR_W-1:0]   daddr_q, daddr_d;
   logic                dwe_q, dwe_d;
   logic [DATA_W-1:0]   dwdata_q, dwdata_d;
   logic [DATA_W-1:0]   rf_q [NREG];
   logic [DATA_W-1:0]   rf_d [NREG];
   logic                retire_c;

   logic [4:0]          opcode;
   logic [REG_AW-1:0]   rd, rs1, rs2;
   logic [DATA_W-1:0]   imm_sext, imm_zext, joff_sext, alu_res;

   assign opcode    = ir_q[DATA_W-1 -: 5];
   assign rd        = ir_q[DATA_W-6 -: REG_AW];
   assign rs1       = ir_q[DATA_W-6-REG_AW -: REG_AW];
   assign rs2       = ir_q[REG_AW:1];
   assign imm_sext  = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
   assign imm_zext  = {{(DATA_W-5){1'b0}}, ir_q[4:0]};
   assign joff_sext = {{5{ir_q[DATA_W-6]}}, ir_q[DATA_W-6:0]};

   // Default result is rs1 + sext(imm5): covers ADDI and the LD/ST effective address.
   always_comb begin
      alu_res = a_q + imm_sext;
      case (opcode)
         OP_ADD:  alu_res = a_q + b_q;
         OP_SUB:  alu_res = a_q - b_q;
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_ANDI: alu_res = a_q & imm_zext;
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      daddr_d  = daddr_q;
      dwe_d    = dwe_q;
      dwdata_d = dwdata_q;
      rf_d     = rf_q;
      retire_c = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (run && imem_ack) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = rf_q[rs1];
            b_d     = (opcode == OP_ST || opcode == OP_BEQ) ? rf_q[rd] : rf_q[rs2];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (opcode <= OP_ANDI) begin
               res_d   = alu_res;
               state_d = S_WB;
            end else if (opcode == OP_LD || opcode == OP_ST) begin
               daddr_d  = ADDR_W'(alu_res);
               dwe_d    = (opcode == OP_ST);
               dwdata_d = b_q;
               state_d  = S_MEM;
            end else begin
               // BEQ/JMP offsets apply to the already-incremented PC.
               retire_c = 1'b1;
               state_d  = (opcode == OP_HALT) ? S_HALT : S_FETCH;
               if (opcode == OP_BEQ && a_q == b_q) pc_d = pc_q + ADDR_W'(imm_sext);
               if (opcode == OP_JMP)               pc_d = pc_q + ADDR_W'(joff_sext);
            end
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (dwe_q) begin
                  retire_c = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  res_d   = dmem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            if (!(R0_ZERO && rd == '0)) rf_d[rd] = res_q;
            retire_c = 1'b1;
            state_d  = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= ADDR_W'(RESET_PC);
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         daddr_q  <= '0;
         dwe_q    <= 1'b0;
         dwdata_q <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         daddr_q  <= daddr_d;
         dwe_q    <= dwe_d;
         dwdata_q <= dwdata_d;
         rf_q     <= rf_d;
      end
   end

   // Fetch request is gated by reset so it drops the instant reset asserts, even with run high.
   assign imem_req   = (state_q == S_FETCH) && run && !reset;
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == S_MEM);
   assign dmem_we    = dwe_q;
   assign dmem_addr  = daddr_q;
   assign dmem_wdata = dwdata_q;
   assign pc_out     = pc_q;
   assign state_out  = state_q;
   assign retire     = retire_c;
   assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed-program bench for multicycle_cpu_core: wait-state memory models plus a
// scoreboard monitor that checks fetch addresses, data accesses and retire latencies.
module tb_multicycle_cpu_core;
   localparam int DW = 18;
   localparam int AW = 12;
   localparam logic [DW-1:0] HALT_W = 18'h3E000;
   localparam logic [DW-1:0] JUNK_W = 18'h15555;

   typedef struct {
      logic        we;
      int          addr;
      int          data;
      int          hold;
   } dexp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          run = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [DW-1:0] imem_rdata = '0;
   logic          dmem_req;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ack = 1'b0;
   logic [DW-1:0] dmem_rdata = '0;
   logic [AW-1:0] pc_out;
   logic [2:0]    state_out;
   logic          retire;
   logic          halted;

   multicycle_cpu_core dut (
      .clk(clk), .reset(reset), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .pc_out(pc_out), .state_out(state_out), .retire(retire), .halted(halted)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] imem [4096];
   logic [DW-1:0] dmem [4096];
   int idelay = 0, ddelay = 0, icnt = 0, dcnt = 0;
   bit spur = 1'b0;
   int checks = 0, errors = 0;
   int exp_fetch[$];
   int exp_lat[$];
   dexp_t exp_dm[$];
   int retire_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] enc_r(input logic [31:0] op, rd, rs1, rs2);
      return {op[4:0], rd[3:0], rs1[3:0], rs2[3:0], 1'b0};
   endfunction
   function automatic logic [DW-1:0] enc_i(input logic [31:0] op, rd, rs1, imm);
      return {op[4:0], rd[3:0], rs1[3:0], imm[4:0]};
   endfunction
   function automatic logic [DW-1:0] enc_j(input logic [31:0] off);
      return {5'd10, off[12:0]};
   endfunction

   task automatic push_dm(input logic we, input int addr, input int data, input int hold);
      dexp_t e;
      e.we = we; e.addr = addr; e.data = data; e.hold = hold;
      exp_dm.push_back(e);
   endtask

   // Memory responders: react #2 after each rising edge so acks are stable at the next edge.
   initial forever begin
      @(posedge clk); #2;
      if (imem_req) begin
         if (icnt >= idelay) begin imem_ack = 1'b1; imem_rdata = imem[imem_addr]; icnt = 0; end
         else begin imem_ack = 1'b0; icnt++; end
      end else begin
         imem_ack = spur; imem_rdata = JUNK_W; icnt = 0;
      end
      if (dmem_req) begin
         if (dcnt >= ddelay) begin
            dmem_ack = 1'b1; dcnt = 0;
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            else dmem_rdata = dmem[dmem_addr];
         end else begin dmem_ack = 1'b0; dcnt++; end
      end else begin
         dmem_ack = spur; dmem_rdata = JUNK_W; dcnt = 0;
      end
   end

   // Scoreboard monitor, sampling on the falling edge.
   initial begin
      int cyc = 0, start = 0, d_cyc = 0;
      bit in_instr = 0, d_active = 0;
      logic d_we_h;
      logic [AW-1:0] d_addr_h;
      logic [DW-1:0] d_wdata_h;
      dexp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            in_instr = 0; d_active = 0;
         end else begin
            if (halted) chk("no_req_while_halted", {31'd0, imem_req | dmem_req}, 0);
            if (imem_req && !in_instr) begin in_instr = 1; start = cyc; end
            if (imem_req && imem_ack) begin
               if (exp_fetch.size() == 0) begin
                  errors++; $display("FAIL fetch_unexpected: got addr 0x%0h, expected none", imem_addr);
               end else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
            end
            if (dmem_req) begin
               if (!d_active) begin
                  d_active = 1; d_cyc = 0;
                  d_we_h = dmem_we; d_addr_h = dmem_addr; d_wdata_h = dmem_wdata;
               end else begin
                  chk("dm_addr_stable", dmem_addr, d_addr_h);
                  chk("dm_wdata_stable", dmem_wdata, d_wdata_h);
                  chk("dm_we_stable", dmem_we, d_we_h);
               end
               d_cyc++;
               if (dmem_ack) begin
                  d_active = 0;
                  if (exp_dm.size() == 0) begin
                     errors++; $display("FAIL dm_unexpected: got addr 0x%0h, expected none", dmem_addr);
                  end else begin
                     e = exp_dm.pop_front();
                     chk("dm_we", dmem_we, e.we);
                     chk("dm_addr", dmem_addr, e.addr);
                     chk("dm_hold_cycles", d_cyc, e.hold);
                     if (e.we) chk("dm_wdata", dmem_wdata, e.data);
                  end
               end
            end
            if (retire) begin
               retire_cnt++;
               if (exp_lat.size() == 0) begin
                  errors++; $display("FAIL retire_unexpected: got retire at pc 0x%0h, expected none", pc_out);
               end else chk("retire_latency", cyc - start + 1, exp_lat.pop_front());
               in_instr = 0;
            end
         end
      end
   end

   task automatic start_test(input int idly, input int ddly, input bit spur_i);
      @(negedge clk);
      reset = 1'b1; run = 1'b0;
      idelay = idly; ddelay = ddly; spur = spur_i;
      exp_fetch.delete(); exp_lat.delete(); exp_dm.delete();
      for (int i = 0; i < 4096; i++) begin imem[i] = HALT_W; dmem[i] = '0; end
   endtask

   task automatic go();
      run = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1 run = 1'b1;
   endtask

   task automatic run_until_halt(input int budget);
      int n = 0;
      while (!halted && n < budget) begin @(negedge clk); n++; end
      chk("halt_reached", {31'd0, halted}, 1);
      repeat (3) @(negedge clk);
      chk("fetch_queue_drained", exp_fetch.size(), 0);
      chk("retire_queue_drained", exp_lat.size(), 0);
      chk("dm_queue_drained", exp_dm.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_imem_req"}, imem_req, 0);
      chk({tag, "_dmem_req"}, dmem_req, 0);
      chk({tag, "_dmem_we"}, dmem_we, 0);
      chk({tag, "_dmem_addr"}, dmem_addr, 0);
      chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
      chk({tag, "_pc_out"}, pc_out, 0);
      chk({tag, "_state"}, state_out, 0);
      chk({tag, "_retire"}, retire, 0);
      chk({tag, "_halted"}, halted, 0);
   endtask

   initial begin
      int n;
      int r0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("por");

      // Reset asserted while a store is waiting for its ack.
      start_test(0, 50, 0);
      imem[0] = enc_i(5, 1, 0, 7);
      imem[1] = enc_i(8, 1, 0, 4);
      exp_fetch = '{0, 1}; exp_lat = '{4};
      go();
      n = 0;
      while (!dmem_req && n < 50) begin @(negedge clk); n++; end
      chk("st_req_seen", dmem_req, 1);
      repeat (2) @(negedge clk);
      chk("st_wait_addr", dmem_addr, 4);
      chk("st_wait_wdata", dmem_wdata, 7);
      chk("st_wait_we", dmem_we, 1);
      #2 reset = 1'b1;
      #1 chk_reset_outputs("midmem");
      chk("midmem_fetch_q", exp_fetch.size(), 0);
      chk("midmem_retire_q", exp_lat.size(), 0);
      ddelay = 0;
      exp_fetch = '{0, 1, 2}; exp_lat = '{4, 4, 3};
      push_dm(1, 4, 7, 1);
      go();
      run_until_halt(200);

      // ALU ops, R0 write drop, results observed through stores.
      start_test(0, 0, 0);
      imem[0]  = enc_i(5, 1, 0, -3);
      imem[1]  = enc_r(0, 2, 1, 1);
      imem[2]  = enc_i(5, 0, 0, 5);
      imem[3]  = enc_r(1, 3, 1, 2);
      imem[4]  = enc_r(4, 4, 1, 2);
      imem[5]  = enc_r(2, 5, 1, 2);
      imem[6]  = enc_r(3, 6, 1, 2);
      imem[7]  = enc_i(6, 7, 1, 31);
      for (int i = 0; i < 7; i++) imem[8+i] = enc_i(8, (i == 0) ? 2 : (i == 1) ? 0 : i + 1, 0, i);
      for (int i = 0; i < 16; i++) exp_fetch.push_back(i);
      for (int i = 0; i < 15; i++) exp_lat.push_back(4);
      exp_lat.push_back(3);
      push_dm(1, 0, 'h3FFFA, 1); push_dm(1, 1, 0, 1);       push_dm(1, 2, 3, 1);
      push_dm(1, 3, 7, 1);       push_dm(1, 4, 'h3FFF8, 1); push_dm(1, 5, 'h3FFFF, 1);
      push_dm(1, 6, 'h1D, 1);
      go();
      run_until_halt(300);

      // Loads and stores with two data wait states.
      start_test(0, 2, 0);
      dmem[9] = 18'h2ABCD;
      imem[0] = enc_i(5, 1, 0, 11);
      imem[1] = enc_i(8, 1, 0, 4);
      imem[2] = enc_i(7, 3, 0, 4);
      imem[3] = enc_i(8, 3, 0, 5);
      imem[4] = enc_i(7, 4, 1, -2);
      imem[5] = enc_i(8, 4, 0, 6);
      exp_fetch = '{0, 1, 2, 3, 4, 5, 6}; exp_lat = '{4, 6, 7, 6, 7, 6, 3};
      push_dm(1, 4, 11, 3); push_dm(0, 4, 0, 3); push_dm(1, 5, 11, 3);
      push_dm(0, 9, 0, 3);  push_dm(1, 6, 'h2ABCD, 3);
      go();
      run_until_halt(300);

      // BEQ taken back to 9, then not taken to 11; one fetch wait state.
      start_test(1, 0, 0);
      imem[0]  = enc_j(9);
      imem[9]  = enc_i(5, 1, 1, 1);
      imem[10] = enc_i(9, 1, 2, -2);
      exp_fetch = '{0, 10, 9, 10, 11}; exp_lat = '{4, 4, 5, 4, 4};
      go();
      run_until_halt(200);
      chk("beq_pc_after_halt", pc_out, 12);

      // JMP wrapping through 0xFFF.
      start_test(0, 0, 0);
      imem[0]     = enc_j(-2);
      imem[12'hFFF] = enc_j(1);
      exp_fetch = '{0, 'hFFF, 1}; exp_lat = '{3, 3, 3};
      go();
      run_until_halt(200);
      chk("jmp_wrap_pc", pc_out, 2);

      // Sequential fetch wrapping from 0xFFF to 0x000.
      start_test(0, 0, 0);
      imem[0]       = enc_i(9, 1, 0, -3);
      imem[12'hFFE] = enc_i(5, 1, 0, 1);
      imem[12'hFFF] = enc_i(12, 0, 0, 0);
      exp_fetch = '{0, 'hFFE, 'hFFF, 0, 1}; exp_lat = '{3, 4, 3, 3, 3};
      go();
      run_until_halt(200);

      // HALT is sticky under run toggling and spurious acks.
      start_test(0, 0, 1);
      exp_fetch = '{0}; exp_lat = '{3};
      r0 = retire_cnt;
      go();
      run_until_halt(100);
      for (int i = 0; i < 20; i++) begin @(negedge clk); run = ~run; end
      chk("halt_sticky", halted, 1);
      chk("halt_state", state_out, 5);
      chk("halt_retire_once", retire_cnt - r0, 1);
      chk("halt_pc", pc_out, 1);
      @(negedge clk); reset = 1'b1; run = 1'b1;
      #1 chk("rst_gates_imem_req", imem_req, 0);
      run = 1'b0;
      @(negedge clk); reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("run0_no_req", imem_req, 0);
      chk("run0_in_fetch", state_out, 0);
      chk("run0_pc", pc_out, 0);
      exp_fetch = '{0}; exp_lat = '{3};
      @(posedge clk); #1 run = 1'b1;
      run_until_halt(100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by t=%0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
